// File: rtl/ysyx_22050550_mul_ctrl_pkg.sv
// Shared encodings for the RV64M multiply controller: op codes, Booth
// signedness codes and controller states.
package ysyx_22050550_mul_ctrl_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_MULW   = 3'b100;

  localparam logic [1:0] SGN_SS = 2'b11;
  localparam logic [1:0] SGN_SU = 2'b10;
  localparam logic [1:0] SGN_UU = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_BUSY  = 2'd2,
    ST_RESP  = 2'd3
  } mul_state_e;

  // Undefined op codes behave exactly like MUL everywhere downstream.
  function automatic logic [2:0] op_norm(input logic [2:0] op);
    return (op > OP_MULW) ? OP_MUL : op;
  endfunction

  function automatic logic [1:0] op_signed(input logic [2:0] op);
    case (op)
      OP_MULHSU: return SGN_SU;
      OP_MULHU:  return SGN_UU;
      default:   return SGN_SS;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050550_mul_ctrl_reuse.sv
// Single-entry reuse buffer: remembers the last full 128-bit product and
// answers a repeated operand pair without touching the multiplier.
module ysyx_22050550_MulReuseBuf
  import ysyx_22050550_mul_ctrl_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            wr_en,
  input  logic [XLEN-1:0] wr_src1,
  input  logic [XLEN-1:0] wr_src2,
  input  logic [1:0]      wr_signed,
  input  logic [XLEN-1:0] wr_result_h,
  input  logic [XLEN-1:0] wr_result_l,
  input  logic [2:0]      lk_op,
  input  logic [XLEN-1:0] lk_src1,
  input  logic [XLEN-1:0] lk_src2,
  output logic            hit,
  output logic [XLEN-1:0] hit_data
);

  logic            valid_q;
  logic [XLEN-1:0] src1_q, src2_q, res_h_q, res_l_q;
  logic [1:0]      signed_q;
  logic            opnd_match;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      valid_q  <= 1'b0;
      src1_q   <= '0;
      src2_q   <= '0;
      signed_q <= '0;
      res_h_q  <= '0;
      res_l_q  <= '0;
    end else if (wr_en) begin
      valid_q  <= 1'b1;
      src1_q   <= wr_src1;
      src2_q   <= wr_src2;
      signed_q <= wr_signed;
      res_h_q  <= wr_result_h;
      res_l_q  <= wr_result_l;
    end
  end

  assign opnd_match = valid_q && (lk_src1 == src1_q) && (lk_src2 == src2_q);

  // The low half is signedness-independent, so MUL may reuse any entry.
  always_comb begin
    hit      = 1'b0;
    hit_data = res_h_q;
    if (opnd_match && lk_op != OP_MULW) begin
      if (lk_op == OP_MUL) begin
        hit      = 1'b1;
        hit_data = res_l_q;
      end else begin
        hit = (signed_q == op_signed(lk_op));
      end
    end
  end

endmodule

// File: rtl/ysyx_22050550_mul_ctrl.sv
// Sequences RV64M multiply ops from the EXU onto the shared Booth multiplier,
// with an optional one-entry reuse buffer for MULH/MUL pairs.
//
// state    | meaning
// ST_IDLE  | ready for a request; reuse lookup on accept
// ST_ISSUE | operands latched, waiting for MulReady to pulse MulValid
// ST_BUSY  | multiplier running, waiting for OutValid
// ST_RESP  | result held under RespValid until RespReady
module ysyx_22050550_mul_ctrl
  import ysyx_22050550_mul_ctrl_pkg::*;
#(
  parameter int XLEN     = 64,
  parameter bit REUSE_EN = 1'b1
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            io_Exu_ReqValid,
  output logic            io_Exu_ReqReady,
  input  logic [2:0]      io_Exu_Op,
  input  logic [XLEN-1:0] io_Exu_Src1,
  input  logic [XLEN-1:0] io_Exu_Src2,
  input  logic            io_Exu_Flush,
  output logic            io_Exu_RespValid,
  input  logic            io_Exu_RespReady,
  output logic [XLEN-1:0] io_Exu_Result,
  output logic            io_Mul_MulValid,
  output logic            io_Mul_Flush,
  output logic            io_Mul_Mulw,
  output logic [1:0]      io_Mul_MulSigned,
  output logic [XLEN-1:0] io_Mul_Multiplicand,
  output logic [XLEN-1:0] io_Mul_Multiplier,
  input  logic            io_Mul_MulReady,
  input  logic            io_Mul_OutValid,
  input  logic [XLEN-1:0] io_Mul_ResultH,
  input  logic [XLEN-1:0] io_Mul_ResultL
);

  mul_state_e      state, state_nxt;
  logic [2:0]      op_q, op_in;
  logic [XLEN-1:0] src1_q, src2_q, result_q;
  logic            mulw_q;
  logic [1:0]      signed_q;
  logic            accept, out_take, buf_wr, hit;
  logic [XLEN-1:0] hit_data, out_sel;

  assign op_in    = op_norm(io_Exu_Op);
  assign accept   = (state == ST_IDLE) && io_Exu_ReqValid && !io_Exu_Flush;
  assign out_take = (state == ST_BUSY) && io_Mul_OutValid && !io_Exu_Flush;
  assign buf_wr   = out_take && !mulw_q;

  generate
    if (REUSE_EN) begin : g_reuse
      ysyx_22050550_MulReuseBuf #(.XLEN(XLEN)) u_reuse (
        .clock       (clock),
        .reset       (reset),
        .wr_en       (buf_wr),
        .wr_src1     (src1_q),
        .wr_src2     (src2_q),
        .wr_signed   (signed_q),
        .wr_result_h (io_Mul_ResultH),
        .wr_result_l (io_Mul_ResultL),
        .lk_op       (op_in),
        .lk_src1     (io_Exu_Src1),
        .lk_src2     (io_Exu_Src2),
        .hit         (hit),
        .hit_data    (hit_data)
      );
    end else begin : g_no_reuse
      assign hit      = 1'b0;
      assign hit_data = '0;
    end
  endgenerate

  always_comb begin
    out_sel = io_Mul_ResultH;
    if (mulw_q) begin
      out_sel = {{(XLEN-32){io_Mul_ResultL[31]}}, io_Mul_ResultL[31:0]};
    end else if (op_q == OP_MUL) begin
      out_sel = io_Mul_ResultL;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = hit ? ST_RESP : ST_ISSUE;
      end
      ST_ISSUE: begin
        if (io_Exu_Flush)         state_nxt = ST_IDLE;
        else if (io_Mul_MulReady) state_nxt = ST_BUSY;
      end
      ST_BUSY: begin
        if (io_Exu_Flush)         state_nxt = ST_IDLE;
        else if (io_Mul_OutValid) state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (io_Exu_Flush || io_Exu_RespReady) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Operand/control registers only load on accept, so they stay frozen
  // across ISSUE and BUSY while the multiplier re-reads them each cycle.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      op_q     <= '0;
      src1_q   <= '0;
      src2_q   <= '0;
      mulw_q   <= 1'b0;
      signed_q <= '0;
      result_q <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_q     <= op_in;
        src1_q   <= io_Exu_Src1;
        src2_q   <= io_Exu_Src2;
        mulw_q   <= (op_in == OP_MULW);
        signed_q <= op_signed(op_in);
        if (hit) result_q <= hit_data;
      end
      if (out_take) result_q <= out_sel;
    end
  end

  assign io_Exu_ReqReady     = (state == ST_IDLE);
  assign io_Exu_RespValid    = (state == ST_RESP);
  assign io_Exu_Result       = result_q;
  assign io_Mul_MulValid     = (state == ST_ISSUE) && io_Mul_MulReady && !io_Exu_Flush;
  assign io_Mul_Flush        = io_Exu_Flush && (state == ST_BUSY);
  assign io_Mul_Mulw         = mulw_q;
  assign io_Mul_MulSigned    = signed_q;
  assign io_Mul_Multiplicand = src1_q;
  assign io_Mul_Multiplier   = src2_q;

endmodule

// File: tb/tb_ysyx_22050550_mul_ctrl.sv
// Bench for the multiply controller: behavioural multiplier stub, directed
// vector table, hand-written flush/reset sequences and a random phase.
module tb_ysyx_22050550_mul_ctrl;

  localparam int XLEN  = 64;
  localparam bit REUSE = 1'b1;

  logic            clock = 1'b0;
  logic            reset = 1'b1;
  logic            io_Exu_ReqValid = 1'b0;
  logic            io_Exu_ReqReady;
  logic [2:0]      io_Exu_Op = 3'd0;
  logic [XLEN-1:0] io_Exu_Src1 = '0;
  logic [XLEN-1:0] io_Exu_Src2 = '0;
  logic            io_Exu_Flush = 1'b0;
  logic            io_Exu_RespValid;
  logic            io_Exu_RespReady = 1'b0;
  logic [XLEN-1:0] io_Exu_Result;
  logic            io_Mul_MulValid;
  logic            io_Mul_Flush;
  logic            io_Mul_Mulw;
  logic [1:0]      io_Mul_MulSigned;
  logic [XLEN-1:0] io_Mul_Multiplicand;
  logic [XLEN-1:0] io_Mul_Multiplier;
  logic            io_Mul_MulReady;
  logic            io_Mul_OutValid;
  logic [XLEN-1:0] io_Mul_ResultH;
  logic [XLEN-1:0] io_Mul_ResultL;

  ysyx_22050550_mul_ctrl #(.XLEN(XLEN), .REUSE_EN(REUSE)) dut (
    .clock(clock), .reset(reset),
    .io_Exu_ReqValid(io_Exu_ReqValid), .io_Exu_ReqReady(io_Exu_ReqReady),
    .io_Exu_Op(io_Exu_Op), .io_Exu_Src1(io_Exu_Src1), .io_Exu_Src2(io_Exu_Src2),
    .io_Exu_Flush(io_Exu_Flush), .io_Exu_RespValid(io_Exu_RespValid),
    .io_Exu_RespReady(io_Exu_RespReady), .io_Exu_Result(io_Exu_Result),
    .io_Mul_MulValid(io_Mul_MulValid), .io_Mul_Flush(io_Mul_Flush),
    .io_Mul_Mulw(io_Mul_Mulw), .io_Mul_MulSigned(io_Mul_MulSigned),
    .io_Mul_Multiplicand(io_Mul_Multiplicand), .io_Mul_Multiplier(io_Mul_Multiplier),
    .io_Mul_MulReady(io_Mul_MulReady), .io_Mul_OutValid(io_Mul_OutValid),
    .io_Mul_ResultH(io_Mul_ResultH), .io_Mul_ResultL(io_Mul_ResultL)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] mul128(input logic [63:0] a, input logic [63:0] b,
                                          input bit sa, input bit sb);
    logic [127:0] ea, eb;
    ea = sa ? {{64{a[63]}}, a} : {64'd0, a};
    eb = sb ? {{64{b[63]}}, b} : {64'd0, b};
    return ea * eb;
  endfunction

  function automatic logic [63:0] hi64(input logic [127:0] p);
    return p[127:64];
  endfunction

  function automatic logic [63:0] lo64(input logic [127:0] p);
    return p[63:0];
  endfunction

  // Multiplier stub: 33 cycles from MulValid to OutValid for 64-bit ops,
  // 17 in 32-bit mode; also counts operand changes while it is running.
  int              mcnt = 0;
  int              stab_err = 0;
  logic [63:0]     cap_a, cap_b, rh, rl;
  logic            cap_w;
  logic [1:0]      cap_s;

  assign io_Mul_MulReady = (mcnt == 0);
  assign io_Mul_OutValid = (mcnt == 1);
  assign io_Mul_ResultH  = rh;
  assign io_Mul_ResultL  = rl;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      mcnt <= 0;
      rh   <= '0;
      rl   <= '0;
    end else if (io_Mul_Flush) begin
      mcnt <= 0;
    end else if (mcnt == 0) begin
      if (io_Mul_MulValid) begin
        cap_a <= io_Mul_Multiplicand;
        cap_b <= io_Mul_Multiplier;
        cap_w <= io_Mul_Mulw;
        cap_s <= io_Mul_MulSigned;
        rh    <= hi64(mul128(io_Mul_Multiplicand, io_Mul_Multiplier,
                             io_Mul_MulSigned[1], io_Mul_MulSigned[0]));
        rl    <= lo64(mul128(io_Mul_Multiplicand, io_Mul_Multiplier,
                             io_Mul_MulSigned[1], io_Mul_MulSigned[0]));
        mcnt  <= io_Mul_Mulw ? 17 : 33;
      end
    end else begin
      if (io_Mul_Multiplicand !== cap_a || io_Mul_Multiplier !== cap_b ||
          io_Mul_Mulw !== cap_w || io_Mul_MulSigned !== cap_s)
        stab_err <= stab_err + 1;
      mcnt <= mcnt - 1;
    end
  end

  // Reference model: arithmetic result from the op definition, plus the
  // remembered last non-W operand pair that predicts reuse hits.
  bit          ent_v = 1'b0;
  logic [63:0] ent_a, ent_b;
  logic [1:0]  ent_s;

  function automatic logic [2:0] ref_norm(input logic [2:0] op);
    return (op > 3'd4) ? 3'd0 : op;
  endfunction

  function automatic logic [1:0] ref_sgn(input logic [2:0] op);
    case (ref_norm(op))
      3'd2:    return 2'b10;
      3'd3:    return 2'b00;
      default: return 2'b11;
    endcase
  endfunction

  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [63:0] a,
                                             input logic [63:0] b);
    logic [63:0] lo;
    case (ref_norm(op))
      3'd1: return hi64(mul128(a, b, 1'b1, 1'b1));
      3'd2: return hi64(mul128(a, b, 1'b1, 1'b0));
      3'd3: return hi64(mul128(a, b, 1'b0, 1'b0));
      3'd4: begin
        lo = a * b;
        return {{32{lo[31]}}, lo[31:0]};
      end
      default: return lo64(mul128(a, b, 1'b0, 1'b0));
    endcase
  endfunction

  function automatic bit ref_hit(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (!REUSE || !ent_v || ref_norm(op) == 3'd4 || a !== ent_a || b !== ent_b) return 1'b0;
    return (ref_norm(op) == 3'd0) || (ref_sgn(op) == ent_s);
  endfunction

  task automatic ref_commit(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    if (!ref_hit(op, a, b) && ref_norm(op) != 3'd4) begin
      ent_v = 1'b1;
      ent_a = a;
      ent_b = b;
      ent_s = ref_sgn(op);
    end
  endtask

  // Runs one op from the idle point (#1 after an edge) back to idle.
  task automatic exec(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                      input int hold, output logic [63:0] res, output int lat,
                      output int pulses, output logic [1:0] sgn, output logic w);
    bit unstable;
    int stab0;
    unstable = 1'b0;
    pulses   = 0;
    sgn      = 2'b00;
    w        = 1'b0;
    stab0    = stab_err;
    chk("req_ready_idle", io_Exu_ReqReady, 1);
    io_Exu_ReqValid = 1'b1;
    io_Exu_Op       = op;
    io_Exu_Src1     = a;
    io_Exu_Src2     = b;
    @(posedge clock); #1;
    io_Exu_ReqValid = 1'b0;
    io_Exu_Op       = 3'($urandom);
    io_Exu_Src1     = {$urandom, $urandom};
    io_Exu_Src2     = {$urandom, $urandom};
    lat = 1;
    while (!io_Exu_RespValid && lat < 100) begin
      if (io_Mul_MulValid) begin
        pulses++;
        sgn = io_Mul_MulSigned;
        w   = io_Mul_Mulw;
      end
      @(posedge clock); #1;
      lat++;
    end
    res = io_Exu_Result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clock); #1;
      if (io_Exu_RespValid !== 1'b1 || io_Exu_Result !== res) unstable = 1'b1;
    end
    chk("resp_hold_stable", 64'(unstable), 0);
    chk("operand_hold", 64'(stab_err - stab0), 0);
    io_Exu_RespReady = 1'b1;
    @(posedge clock); #1;
    io_Exu_RespReady = 1'b0;
    chk("resp_handshake_idle", {io_Exu_RespValid, io_Exu_ReqReady}, 64'b01);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a, b, res;
    int          lat, pulses;
    logic [1:0]  sgn;
    logic        w;
    int          hold;
  } vec_t;

  vec_t        tbl[7];
  logic [63:0] r, a, b;
  logic [2:0]  op;
  int          lat, pulses, cnt;
  logic [1:0]  sgn;
  logic        w;
  bit          seen;

  initial begin
    tbl[0] = '{3'd0, 64'd3, 64'hFFFF_FFFF_FFFF_FFFB, 64'hFFFF_FFFF_FFFF_FFF1, 35, 1, 2'b11, 1'b0, 5};
    tbl[1] = '{3'd3, '1, '1, 64'hFFFF_FFFF_FFFF_FFFE, 35, 1, 2'b00, 1'b0, 0};
    tbl[2] = '{3'd0, '1, '1, 64'd1, 1, 0, 2'b00, 1'b0, 0};
    tbl[3] = '{3'd1, '1, '1, 64'd0, 35, 1, 2'b11, 1'b0, 0};
    tbl[4] = '{3'd2, '1, '1, '1, 35, 1, 2'b10, 1'b0, 0};
    tbl[5] = '{3'd4, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 19, 1, 2'b11, 1'b1, 0};
    tbl[6] = '{3'd0, '1, '1, 64'd1, 1, 0, 2'b00, 1'b0, 0};

    #12;
    chk("rst_req_ready", io_Exu_ReqReady, 1);
    chk("rst_resp_valid", io_Exu_RespValid, 0);
    chk("rst_mul_valid", io_Mul_MulValid, 0);
    chk("rst_result", io_Exu_Result, 0);
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;

    for (int i = 0; i < 7; i++) begin
      exec(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].hold, r, lat, pulses, sgn, w);
      chk($sformatf("vec%0d_result", i), r, tbl[i].res);
      chk($sformatf("vec%0d_latency", i), 64'(lat), 64'(tbl[i].lat));
      chk($sformatf("vec%0d_mulvalid_pulses", i), 64'(pulses), 64'(tbl[i].pulses));
      if (tbl[i].pulses != 0) begin
        chk($sformatf("vec%0d_mulsigned", i), 64'(sgn), 64'(tbl[i].sgn));
        chk($sformatf("vec%0d_mulw", i), 64'(w), 64'(tbl[i].w));
      end
      ref_commit(tbl[i].op, tbl[i].a, tbl[i].b);
    end

    // Flush with a request in IDLE drops it.
    io_Exu_ReqValid = 1'b1; io_Exu_Op = 3'd0; io_Exu_Src1 = 64'd9; io_Exu_Src2 = 64'd9;
    io_Exu_Flush = 1'b1;
    @(posedge clock); #1;
    io_Exu_ReqValid = 1'b0; io_Exu_Flush = 1'b0;
    chk("idle_flush_drop_ready", io_Exu_ReqReady, 1);
    chk("idle_flush_drop_mulvalid", io_Mul_MulValid, 0);

    // Flush on the 10th BUSY cycle.
    io_Exu_ReqValid = 1'b1; io_Exu_Op = 3'd0; io_Exu_Src1 = 64'd11; io_Exu_Src2 = 64'd13;
    @(posedge clock); #1;
    io_Exu_ReqValid = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    chk("busy_mul_flush_idle", io_Mul_Flush, 0);
    io_Exu_Flush = 1'b1;
    #1;
    chk("busy_mul_flush_pulse", io_Mul_Flush, 1);
    @(posedge clock); #1;
    io_Exu_Flush = 1'b0;
    chk("busy_flush_req_ready", io_Exu_ReqReady, 1);
    chk("busy_flush_mul_flush_low", io_Mul_Flush, 0);
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (io_Exu_RespValid) seen = 1'b1;
      @(posedge clock); #1;
    end
    chk("busy_flush_no_resp", 64'(seen), 0);
    exec(3'd0, 64'd6, 64'd7, 0, r, lat, pulses, sgn, w);
    chk("after_flush_mul_result", r, 64'd42);
    chk("after_flush_mul_latency", 64'(lat), 35);
    ref_commit(3'd0, 64'd6, 64'd7);

    // Flush in RESP drops the response (MULW leaves the reuse entry alone).
    io_Exu_ReqValid = 1'b1; io_Exu_Op = 3'd4; io_Exu_Src1 = 64'd5; io_Exu_Src2 = 64'd5;
    @(posedge clock); #1;
    io_Exu_ReqValid = 1'b0;
    cnt = 0;
    while (!io_Exu_RespValid && cnt < 100) begin
      @(posedge clock); #1;
      cnt++;
    end
    chk("resp_flush_reached_resp", io_Exu_RespValid, 1);
    chk("resp_flush_result", io_Exu_Result, 64'd25);
    io_Exu_Flush = 1'b1;
    @(posedge clock); #1;
    io_Exu_Flush = 1'b0;
    chk("resp_flush_dropped", {io_Exu_RespValid, io_Exu_ReqReady}, 64'b01);

    // Async reset mid-BUSY, then a repeat of a buffered pair must miss.
    exec(3'd1, 64'h1234, 64'h5678, 0, r, lat, pulses, sgn, w);
    ref_commit(3'd1, 64'h1234, 64'h5678);
    io_Exu_ReqValid = 1'b1; io_Exu_Op = 3'd3; io_Exu_Src1 = 64'hABC; io_Exu_Src2 = 64'hDEF;
    @(posedge clock); #1;
    io_Exu_ReqValid = 1'b0;
    repeat (8) @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    chk("midrst_req_ready", io_Exu_ReqReady, 1);
    chk("midrst_resp_valid", io_Exu_RespValid, 0);
    chk("midrst_result", io_Exu_Result, 0);
    chk("midrst_mulsigned", io_Mul_MulSigned, 0);
    chk("midrst_multiplicand", io_Mul_Multiplicand, 0);
    chk("midrst_multiplier", io_Mul_Multiplier, 0);
    chk("midrst_mulw", io_Mul_Mulw, 0);
    ent_v = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    @(posedge clock); #1;
    exec(3'd1, 64'h1234, 64'h5678, 0, r, lat, pulses, sgn, w);
    chk("post_rst_repeat_pulses", 64'(pulses), 1);
    chk("post_rst_repeat_result", r, ref_result(3'd1, 64'h1234, 64'h5678));
    ref_commit(3'd1, 64'h1234, 64'h5678);

    // Random ops against the reference model, biased toward repeated pairs.
    a = 64'd1; b = 64'd1;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) < 4) begin
        a = ent_v ? ent_a : a;
        b = ent_v ? ent_b : b;
      end else begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
      end
      exec(op, a, b, $urandom_range(0, 3), r, lat, pulses, sgn, w);
      chk($sformatf("rnd%0d_result", i), r, ref_result(op, a, b));
      chk($sformatf("rnd%0d_latency", i), 64'(lat),
          ref_hit(op, a, b) ? 64'd1 : (ref_norm(op) == 3'd4 ? 64'd19 : 64'd35));
      chk($sformatf("rnd%0d_pulses", i), 64'(pulses), ref_hit(op, a, b) ? 64'd0 : 64'd1);
      if (!ref_hit(op, a, b)) begin
        chk($sformatf("rnd%0d_mulsigned", i), 64'(sgn), 64'(ref_sgn(op)));
        chk($sformatf("rnd%0d_mulw", i), 64'(w), 64'(ref_norm(op) == 3'd4));
      end
      ref_commit(op, a, b);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
